// File: rtl/i4004_bus_master.sv
// MCS-4 style bus master: runs 8-phase frames (address out, opcode fetch, execute) on a 4-bit OR bus.
// Define MCS4_BUS_IO_CYCLES_EN to enable the WRR/RDR/SRC I/O cycles; without it only fetches run.
module i4004_bus_master (
    input  logic        clk,
    input  logic        rst,
    output logic        sync,
    output logic        cl_rom,
    output logic        cm_rom,
    input  logic [3:0]  dbus_in,
    output logic [3:0]  dbus_out,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_pc,
    input  logic [3:0]  req_acc,
    input  logic [7:0]  req_src,
    output logic        rsp_valid,
    output logic [7:0]  rsp_instr,
    output logic [3:0]  rsp_io,
    output logic        rsp_io_valid
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    state_t      state_r;
    logic [2:0]  phase_r;
    logic [11:0] pc_r;
    logic [3:0]  acc_r;
    logic [7:0]  src_r;
    logic [3:0]  opr_r;
    logic [3:0]  opa_r;
    logic        cm_rom_r;
    logic        cl_rom_r;
    logic        rsp_valid_r;
    logic [7:0]  rsp_instr_r;
    logic [3:0]  rsp_io_r;
    logic        rsp_io_valid_r;

    logic        idle_or_x3_s;
    logic        accept_s;
    logic [3:0]  dbus_s;

    function automatic logic is_wrr(input logic [3:0] opr, input logic [3:0] opa);
        return (opr == 4'hE) && (opa == 4'h2);
    endfunction

    function automatic logic is_rdr(input logic [3:0] opr, input logic [3:0] opa);
        return (opr == 4'hE) && (opa == 4'hA);
    endfunction

    function automatic logic is_src(input logic [3:0] opr, input logic [3:0] opa);
        return (opr == 4'h2) && opa[0];
    endfunction

`ifndef MCS4_BUS_IO_CYCLES_EN
    // Accumulator and register-pair inputs only feed the I/O cycles.
    logic io_unused_s;
    assign io_unused_s = ^{req_acc, req_src, acc_r, src_r};
`endif

    // Frame boundary decode: sync parks the slaves at A1 and a new request may enter.
    always_comb begin
        idle_or_x3_s = (state_r == ST_IDLE) || (phase_r == PH_X3);
        accept_s     = req_valid && idle_or_x3_s;
    end

    // Bus drive decode from state, phase and the frame's latched request/opcode.
    always_comb begin
        dbus_s = 4'h0;
        if (state_r == ST_RUN) begin
            case (phase_r)
                PH_A1:   dbus_s = pc_r[3:0];
                PH_A2:   dbus_s = pc_r[7:4];
                PH_A3:   dbus_s = pc_r[11:8];
`ifdef MCS4_BUS_IO_CYCLES_EN
                PH_X2: begin
                    if (is_wrr(opr_r, opa_r)) begin
                        dbus_s = acc_r;
                    end else if (is_src(opr_r, opa_r)) begin
                        dbus_s = src_r[7:4];
                    end else begin
                        dbus_s = 4'h0;
                    end
                end
                PH_X3: begin
                    if (is_src(opr_r, opa_r)) begin
                        dbus_s = src_r[3:0];
                    end else begin
                        dbus_s = 4'h0;
                    end
                end
`endif
                default: dbus_s = 4'h0;
            endcase
        end else begin
            dbus_s = 4'h0;
        end
    end

    assign sync         = idle_or_x3_s;
    assign req_ready    = idle_or_x3_s;
    assign dbus_out     = dbus_s;
    assign cm_rom       = cm_rom_r;
    assign cl_rom       = cl_rom_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_instr    = rsp_instr_r;
    assign rsp_io       = rsp_io_r;
    assign rsp_io_valid = rsp_io_valid_r;

    // Frame sequencer, request latch, opcode capture and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            phase_r        <= PH_A1;
            pc_r           <= 12'h000;
            acc_r          <= 4'h0;
            src_r          <= 8'h00;
            opr_r          <= 4'h0;
            opa_r          <= 4'h0;
            cm_rom_r       <= 1'b0;
            cl_rom_r       <= 1'b1;
            rsp_valid_r    <= 1'b0;
            rsp_instr_r    <= 8'h00;
            rsp_io_r       <= 4'h0;
            rsp_io_valid_r <= 1'b0;
        end else begin
            cl_rom_r    <= 1'b0;
            cm_rom_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            if (accept_s) begin
                pc_r  <= req_pc;
                acc_r <= req_acc;
                src_r <= req_src;
            end
            case (state_r)
                ST_IDLE: begin
                    phase_r <= PH_A1;
                    if (accept_s) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    case (phase_r)
                        PH_M1: begin
                            opr_r <= dbus_in;
`ifdef MCS4_BUS_IO_CYCLES_EN
                            cm_rom_r <= (dbus_in == 4'hE);
`endif
                        end
                        PH_M2: opa_r <= dbus_in;
`ifdef MCS4_BUS_IO_CYCLES_EN
                        PH_X1: cm_rom_r <= is_src(opr_r, opa_r);
`endif
                        PH_X2: begin
                            rsp_valid_r <= 1'b1;
                            rsp_instr_r <= {opr_r, opa_r};
`ifdef MCS4_BUS_IO_CYCLES_EN
                            rsp_io_valid_r <= is_rdr(opr_r, opa_r);
                            if (is_rdr(opr_r, opa_r)) begin
                                rsp_io_r <= dbus_in;
                            end
`else
                            rsp_io_valid_r <= 1'b0;
`endif
                        end
                        default: ;
                    endcase
                    // X3 either chains straight into the next frame or drops to idle.
                    if (phase_r == PH_X3) begin
                        phase_r <= PH_A1;
                        if (!accept_s) begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        phase_r <= phase_r + 3'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    phase_r <= PH_A1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i4004_bus_master.sv
// Directed bench for i4004_bus_master: fetch, WRR, RDR, SRC, back-to-back frames and mid-frame reset.
module tb_i4004_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        sync, cl_rom, cm_rom;
    logic [3:0]  dbus_in, dbus_out;
    logic        req_valid, req_ready;
    logic [11:0] req_pc;
    logic [3:0]  req_acc;
    logic [7:0]  req_src;
    logic        rsp_valid;
    logic [7:0]  rsp_instr;
    logic [3:0]  rsp_io;
    logic        rsp_io_valid;

    int errors = 0;
    int checks = 0;

`ifdef MCS4_BUS_IO_CYCLES_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    i4004_bus_master dut (
        .clk(clk), .rst(rst), .sync(sync), .cl_rom(cl_rom), .cm_rom(cm_rom),
        .dbus_in(dbus_in), .dbus_out(dbus_out), .req_valid(req_valid), .req_ready(req_ready),
        .req_pc(req_pc), .req_acc(req_acc), .req_src(req_src), .rsp_valid(rsp_valid),
        .rsp_instr(rsp_instr), .rsp_io(rsp_io), .rsp_io_valid(rsp_io_valid)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame from a ready cycle; the ROM side is played by driving dbus_in per phase.
    task automatic frame(input logic [11:0] pc, input logic [3:0] acc, input logic [7:0] src,
                         input logic [7:0] instr, input logic [3:0] io, input bit keep,
                         input logic [3:0] e_x2, input logic [3:0] e_x3, input logic e_cm_m2,
                         input logic e_cm_x2, input logic e_iov, input logic [3:0] e_io);
        req_valid = 1'b1; req_pc = pc; req_acc = acc; req_src = src;
        chk("ready_before", req_ready, 12'd1);
        step();
        req_valid = keep; req_pc = ~pc; req_acc = ~acc; req_src = ~src;
        chk("a1_sync", sync, 12'd0);
        chk("a1_ready", req_ready, 12'd0);
        chk("a1_dbus", dbus_out, pc[3:0]);
        step();
        chk("a2_dbus", dbus_out, pc[7:4]);
        chk("a2_sync", sync, 12'd0);
        step();
        chk("a3_dbus", dbus_out, pc[11:8]);
        chk("a3_cm", cm_rom, 12'd0);
        step();
        dbus_in = instr[7:4];
        chk("m1_dbus", dbus_out, 12'd0);
        chk("m1_cm", cm_rom, 12'd0);
        step();
        dbus_in = instr[3:0];
        chk("m2_cm", cm_rom, e_cm_m2);
        chk("m2_dbus", dbus_out, 12'd0);
        step();
        dbus_in = 4'h0;
        chk("x1_dbus", dbus_out, 12'd0);
        chk("x1_cm", cm_rom, 12'd0);
        chk("x1_rsp_valid", rsp_valid, 12'd0);
        step();
        dbus_in = io;
        chk("x2_dbus", dbus_out, e_x2);
        chk("x2_cm", cm_rom, e_cm_x2);
        chk("x2_rsp_valid", rsp_valid, 12'd0);
        chk("x2_sync", sync, 12'd0);
        step();
        dbus_in = 4'h0;
        chk("x3_rsp_valid", rsp_valid, 12'd1);
        chk("x3_rsp_instr", rsp_instr, instr);
        chk("x3_rsp_io_valid", rsp_io_valid, e_iov);
        chk("x3_rsp_io", rsp_io, e_io);
        chk("x3_dbus", dbus_out, e_x3);
        chk("x3_sync", sync, 12'd1);
        chk("x3_ready", req_ready, 12'd1);
        chk("x3_cm", cm_rom, 12'd0);
    endtask

    initial begin
        rst = 1'b1; dbus_in = 4'h0; req_valid = 1'b0;
        req_pc = 12'h000; req_acc = 4'h0; req_src = 8'h00;
        step();
        step();
        chk("rst_sync", sync, 12'd1);
        chk("rst_ready", req_ready, 12'd1);
        chk("rst_cm", cm_rom, 12'd0);
        chk("rst_dbus", dbus_out, 12'd0);
        chk("rst_rsp_valid", rsp_valid, 12'd0);
        chk("rst_rsp_io_valid", rsp_io_valid, 12'd0);
        chk("rst_rsp_instr", rsp_instr, 12'd0);
        chk("rst_rsp_io", rsp_io, 12'd0);
        chk("rst_cl", cl_rom, 12'd1);
        rst = 1'b0;
        chk("cl_after_fall", cl_rom, 12'd1);
        step();
        chk("cl_clear", cl_rom, 12'd0);
        chk("idle_sync", sync, 12'd1);

        // Plain fetch
        frame(12'h3A5, 4'h0, 8'h00, 8'hD7, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        step();
        chk("idle_sync_after", sync, 12'd1);
        chk("idle_rsp_valid", rsp_valid, 12'd0);
        chk("rsp_instr_hold", rsp_instr, 12'hD7);

        // WRR
        frame(12'h010, 4'h9, 8'h00, 8'hE2, 4'h0, 1'b0, IO_EN ? 4'h9 : 4'h0, 4'h0,
              IO_EN, 1'b0, 1'b0, 4'h0);
        step();
        // RDR
        frame(12'h011, 4'h0, 8'h00, 8'hEA, 4'h6, 1'b0, 4'h0, 4'h0,
              IO_EN, 1'b0, IO_EN, IO_EN ? 4'h6 : 4'h0);
        step();
        // SRC
        frame(12'h012, 4'h0, 8'h4C, 8'h21, 4'h0, 1'b0, IO_EN ? 4'h4 : 4'h0, IO_EN ? 4'hC : 4'h0,
              1'b0, IO_EN, 1'b0, IO_EN ? 4'h6 : 4'h0);
        step();

        // Three back-to-back frames; 8'h20 is group 2 with OPA[0]=0, so not SRC
        frame(12'h100, 4'h0, 8'hFF, 8'h15, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, IO_EN ? 4'h6 : 4'h0);
        frame(12'h7FF, 4'h0, 8'hFF, 8'h20, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, IO_EN ? 4'h6 : 4'h0);
        frame(12'h800, 4'h0, 8'hFF, 8'hF0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, IO_EN ? 4'h6 : 4'h0);
        step();
        chk("b2b_idle_sync", sync, 12'd1);
        chk("b2b_idle_rsp_valid", rsp_valid, 12'd0);

        // Reset asserted during M2 of an I/O-group frame
        req_valid = 1'b1; req_pc = 12'h0F0;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        dbus_in = 4'hE;
        step();
        dbus_in = 4'h2;
        chk("mr_m2_cm", cm_rom, IO_EN);
        rst = 1'b1;
        step();
        dbus_in = 4'h0;
        chk("mr_sync", sync, 12'd1);
        chk("mr_ready", req_ready, 12'd1);
        chk("mr_rsp_valid", rsp_valid, 12'd0);
        chk("mr_cm", cm_rom, 12'd0);
        chk("mr_cl", cl_rom, 12'd1);
        chk("mr_dbus", dbus_out, 12'd0);
        chk("mr_rsp_instr", rsp_instr, 12'd0);
        chk("mr_rsp_io", rsp_io, 12'd0);
        rst = 1'b0;
        step();
        chk("mr_cl_clear", cl_rom, 12'd0);
        chk("mr_idle_sync", sync, 12'd1);
        chk("mr_no_rsp1", rsp_valid, 12'd0);
        step();
        chk("mr_no_rsp2", rsp_valid, 12'd0);
        frame(12'h123, 4'h0, 8'h00, 8'h4B, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        step();
        chk("final_idle", sync, 12'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
